// File: rtl/vc_plru_tree.sv
// Tree pseudo-LRU victim selector for the fully-associative victim cache.
// Prefers invalid entries; a granted victim is promoted to MRU on the same edge.
module vc_plru_tree #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_en,
    input  logic [IDX_W-1:0] acc_idx,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_idx,
    input  logic             vic_req,
    output logic             vic_vld,
    output logic [IDX_W-1:0] vic_idx,
    output logic             vic_free,
    output logic             all_valid
);

    localparam int NODES = ENTRIES - 1;

    if (ENTRIES < 2 || ENTRIES > 64 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("vc_plru_tree: ENTRIES must be a power of two in 2..64");
    end

    logic [NODES-1:0]   tree_q, tree_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]   sel_idx, lru_idx, inv_first;
    logic               any_invalid;

    // Walk root-to-leaf for entry idx, pointing each node away from it.
    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t,
                                               input logic [IDX_W-1:0] idx);
        logic [NODES-1:0] r;
        int node;
        r    = t;
        node = 0;
        for (int lvl = IDX_W - 1; lvl >= 0; lvl--) begin
            r[node] = ~idx[lvl];
            node    = 2 * node + (idx[lvl] ? 2 : 1);
        end
        return r;
    endfunction

    always_comb begin
        int node;
        lru_idx = '0;
        node    = 0;
        for (int lvl = IDX_W - 1; lvl >= 0; lvl--) begin
            lru_idx[lvl] = tree_q[node];
            node         = 2 * node + (tree_q[node] ? 2 : 1);
        end
    end

    always_comb begin
        inv_first   = '0;
        any_invalid = ~&valid_q;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) inv_first = IDX_W'(i);
        end
        sel_idx = any_invalid ? inv_first : lru_idx;
    end

    // Touch order grant -> fill -> acc, so the later touch wins on shared nodes.
    always_comb begin
        tree_d = tree_q;
        if (vic_req) tree_d = touch(tree_d, sel_idx);
        if (fill_en) tree_d = touch(tree_d, fill_idx);
        if (acc_en)  tree_d = touch(tree_d, acc_idx);
        valid_d = valid_q;
        if (inv_en)  valid_d[inv_idx]  = 1'b0;
        if (fill_en) valid_d[fill_idx] = 1'b1;
    end

    // vic_req has no ready: every asserted cycle is accepted and answered by a
    // single-cycle vic_vld pulse on the next cycle; vic_idx/vic_free hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            tree_q    <= '0;
            valid_q   <= '0;
            vic_vld   <= 1'b0;
            vic_idx   <= '0;
            vic_free  <= 1'b0;
            all_valid <= 1'b0;
        end else begin
            tree_q    <= tree_d;
            valid_q   <= valid_d;
            vic_vld   <= vic_req;
            all_valid <= &valid_q;
            if (vic_req) begin
                vic_idx  <= sel_idx;
                vic_free <= any_invalid;
            end
        end
    end

endmodule
